// File: rtl/hint_7_interp.sv
// Polyphase interpolate-by-2 FIR: each accepted 8-bit sample yields an even-tap
// (phase 0) and an odd-tap (phase 1) 20-bit output on consecutive cycles.
module hint_7_interp #(
    parameter int word_size_in  = 8,
    parameter int word_size_out = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [word_size_in-1:0]  X,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [word_size_out-1:0] Y,
    output logic                     out_valid,
    output logic                     out_phase
);

    localparam int n_taps = 11;
    localparam int ext_w  = word_size_out - word_size_in;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } state_t;

    typedef logic signed [word_size_out-1:0] acc_t;

    state_t                  state_q, state_d;
    logic [word_size_in-1:0] d_q [0:n_taps-1];
    logic [word_size_in-1:0] d_d [0:n_taps-1];
    acc_t                    y_q, y_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_phase_q, out_phase_d;

    acc_t s   [0:n_taps-1];
    acc_t p0  [0:n_taps-1];
    acc_t p1  [0:n_taps-2];
    acc_t sum0, sum1;
    logic accept;

    assign in_ready  = (state_q != PH0);
    assign accept    = in_valid & in_ready;
    assign Y         = y_q;
    assign out_valid = out_valid_q;
    assign out_phase = out_phase_q;

    // Sign-extend every tap once so all shift-add terms share the output width.
    always_comb begin
        for (int k = 0; k < n_taps; k++) begin
            s[k] = acc_t'({{ext_w{d_q[k][word_size_in-1]}}, d_q[k]});
        end
    end

    // Even taps: -1, 8, -9, -31, 133, 253, 77, -37, 1, 5, -1
    always_comb begin
        p0[0]  = -s[0];
        p0[1]  = s[1] <<< 3;
        p0[2]  = -((s[2] <<< 3) + s[2]);
        p0[3]  = s[3] - (s[3] <<< 5);
        p0[4]  = (s[4] <<< 7) + (s[4] <<< 2) + s[4];
        p0[5]  = (s[5] <<< 8) - (s[5] <<< 1) - s[5];
        p0[6]  = (s[6] <<< 6) + (s[6] <<< 4) - (s[6] <<< 1) - s[6];
        p0[7]  = -((s[7] <<< 5) + (s[7] <<< 2) + s[7]);
        p0[8]  = s[8];
        p0[9]  = (s[9] <<< 2) + s[9];
        p0[10] = -s[10];
    end

    // Odd taps: 2, 7, -33, 27, 229, 187, -9, -22, 9, 0
    always_comb begin
        p1[0] = s[0] <<< 1;
        p1[1] = (s[1] <<< 3) - s[1];
        p1[2] = -((s[2] <<< 5) + s[2]);
        p1[3] = (s[3] <<< 5) - (s[3] <<< 2) - s[3];
        p1[4] = (s[4] <<< 8) - (s[4] <<< 5) + (s[4] <<< 2) + s[4];
        p1[5] = (s[5] <<< 7) + (s[5] <<< 6) - (s[5] <<< 2) - s[5];
        p1[6] = -((s[6] <<< 3) + s[6]);
        p1[7] = -((s[7] <<< 4) + (s[7] <<< 2) + (s[7] <<< 1));
        p1[8] = (s[8] <<< 3) + s[8];
        p1[9] = '0;
    end

    always_comb begin
        sum0 = '0;
        sum1 = '0;
        for (int k = 0; k < n_taps; k++) begin
            sum0 = sum0 + p0[k];
        end
        for (int k = 0; k < n_taps - 1; k++) begin
            sum1 = sum1 + p1[k];
        end
    end

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        out_phase_d = out_phase_q;

        if (accept) begin
            for (int k = n_taps - 1; k > 0; k--) begin
                d_d[k] = d_q[k-1];
            end
            d_d[0] = X;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PH0;
                end
            end
            PH0: begin
                y_d         = sum0;
                out_valid_d = 1'b1;
                out_phase_d = 1'b0;
                state_d     = PH1;
            end
            PH1: begin
                // sum1 reads d_q, i.e. the line before any same-cycle shift.
                y_d         = sum1;
                out_valid_d = 1'b1;
                out_phase_d = 1'b1;
                state_d     = accept ? PH0 : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the delay line is reset too, so a restarted filter carries no stale history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_phase_q <= 1'b0;
            for (int k = 0; k < n_taps; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_phase_q <= out_phase_d;
            d_q         <= d_d;
        end
    end

endmodule

// File: tb/tb_hint_7_interp.sv
// Self-checking bench for hint_7_interp: a convolution model over the accepted
// sample history predicts handshake, output stream and held values every cycle.
module tb_hint_7_interp;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  x_in;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] y_out;
    logic        out_valid;
    logic        out_phase;

    hint_7_interp dut (
        .clk       (clk),
        .reset     (reset),
        .X         (x_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (y_out),
        .out_valid (out_valid),
        .out_phase (out_phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int h [0:20] = '{-1, 2, 8, 7, -9, -33, -31, 27, 133, 229, 253,
                     187, 77, -9, -37, -22, 1, 9, 5, 0, -1};

    // Model state: accepted history (newest first) and the two pending output slots.
    int hist [0:10];
    bit s1_v, s2_v;
    int s1_y, s2_y;
    bit s1_p, s2_p;
    int y_hold;
    bit ph_hold;
    bit prev_acc;

    int obs_y [$];
    bit obs_p [$];
    int last_y0, last_y1;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 11; k++) hist[k] = 0;
        s1_v = 0; s2_v = 0; s1_y = 0; s2_y = 0; s1_p = 0; s2_p = 0;
        y_hold = 0; ph_hold = 0; prev_acc = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit v, input logic [7:0] x);
        bit acc;
        bit cur_v;
        int cur_y;
        bit cur_p;
        int a0, a1;
        in_valid = v;
        x_in     = x;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, !prev_acc});
        acc = v && !prev_acc;
        @(posedge clk);
        cur_v = s1_v; cur_y = s1_y; cur_p = s1_p;
        s1_v = s2_v; s1_y = s2_y; s1_p = s2_p;
        s2_v = 0;
        if (acc) begin
            for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'($signed(x));
            a0 = 0;
            a1 = 0;
            for (int k = 0; k <= 10; k++) a0 += h[2*k] * hist[k];
            for (int k = 0; k <= 9; k++)  a1 += h[2*k+1] * hist[k];
            s1_v = 1; s1_y = a0; s1_p = 0;
            s2_v = 1; s2_y = a1; s2_p = 1;
        end
        prev_acc = acc;
        @(negedge clk);
        if (cur_v) begin
            y_hold  = cur_y;
            ph_hold = cur_p;
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, cur_v});
        check("y", $signed(y_out), y_hold);
        check("out_phase", {31'd0, out_phase}, {31'd0, ph_hold});
        if (out_valid === 1'b1) begin
            obs_y.push_back(int'($signed(y_out)));
            obs_p.push_back(out_phase);
            if (out_phase === 1'b0) last_y0 = int'($signed(y_out));
            else                    last_y1 = int'($signed(y_out));
        end
    endtask

    // Impulse (1 then zeros), one accept every 'gap'+1 cycles; stream must equal h[].
    task automatic impulse(input string tag, input int gap);
        obs_y.delete();
        obs_p.delete();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, (i == 0) ? 8'd1 : 8'd0);
            for (int g = 0; g < gap; g++) cycle(1'b0, 8'd0);
        end
        repeat (3) cycle(1'b0, 8'd0);
        check({tag, "_len"}, obs_y.size(), 24);
        for (int i = 0; i < obs_y.size(); i++) begin
            check({tag, "_y"}, obs_y[i], (i < 21) ? h[i] : 0);
            check({tag, "_ph"}, {31'd0, obs_p[i]}, i % 2);
        end
    endtask

    task automatic dc(input logic [7:0] x, input int exp0, input int exp1,
                      input string tag);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, x);
            cycle(1'b0, 8'd0);
        end
        repeat (2) cycle(1'b0, 8'd0);
        check({tag, "_ph0"}, last_y0, exp0);
        check({tag, "_ph1"}, last_y1, exp1);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        x_in     = 8'd0;
        model_reset();
        last_y0 = 0;
        last_y1 = 0;
        repeat (2) @(negedge clk);
        check("rst_y", $signed(y_out), 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        reset = 1'b1;
        @(negedge clk);

        impulse("imp_full", 1);
        impulse("imp_throttle", 4);

        dc(8'd127, 50546, 50419, "dc_max");
        dc(8'h80, -50944, -50816, "dc_min");

        // in_valid held high with a fresh random X every cycle.
        for (int i = 0; i < 60; i++) cycle(1'b1, 8'($urandom));
        // Random valid pattern with random data.
        for (int i = 0; i < 200; i++) cycle(1'($urandom_range(0, 1)), 8'($urandom));
        repeat (3) cycle(1'b0, 8'd0);

        // Reset asserted during the PH1 cycle that follows an accept of 100.
        cycle(1'b1, 8'd100);
        cycle(1'b0, 8'd0);
        #2 reset = 1'b0;
        #1;
        check("midrst_y", $signed(y_out), 0);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_in_ready", {31'd0, in_ready}, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) cycle(1'b0, 8'd0);
        impulse("imp_after_rst", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hint_7_interp.md
Name: hint_7_interp

Overview:
- Polyphase interpolate-by-2 FIR, the up-conversion counterpart of the 21-tap decimating filter in the DecInterp chain. Uses the same coefficient set.
- Each accepted 8-bit input sample produces two filtered 20-bit output samples on consecutive cycles: phase 0 from the even taps, phase 1 from the odd taps.
- Sits between the baseband sample source and the higher-rate datapath; in_valid/in_ready handshake on input, out_valid strobe on output.

Parameters:
- word_size_in, 8, bit-size of X (two's complement).
- word_size_out, 20, bit-size of Y (two's complement); 18 bits needed, 20 kept for chain consistency.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- X  input  word_size_in  input sample, signed.
- in_valid  input  1  X is valid this cycle.
- in_ready  output  1  block accepts X this cycle (combinational from state).
- Y  output  word_size_out  filtered output sample, signed, registered.
- out_valid  output  1  Y holds a new sample this cycle.
- out_phase  output  1  0 = even-tap output, 1 = odd-tap output; valid when out_valid=1.

Behaviour:
- Coefficients h[0..20] are fixed constants: -1,2,8,7,-9,-33,-31,27,133,229,253,187,77,-9,-37,-22,1,9,5,0,-1.
  - Even taps (phase 0): -1,8,-9,-31,133,253,77,-37,1,5,-1.
  - Odd taps (phase 1): 2,7,-33,27,229,187,-9,-22,9,0.
- Multiplications are shift-add only; no generic multipliers.
- Delay line d[0..10] holds the last 11 accepted samples, with d[0] the newest.
  - On accept (in_valid & in_ready at a rising edge): d[k] <= d[k-1], d[0] <= X.
  - No shift otherwise.
- Phase 0 output: sum over k=0..10 of h[2k]*d[k].
- Phase 1 output: sum over k=0..9 of h[2k+1]*d[k].
- Arithmetic is sign-extended to word_size_out; it cannot overflow (max |Y| = 128*556 = 71168).
- FSM states: IDLE, PH0, PH1.
  - IDLE: in_ready=1; accept -> PH0.
  - PH0: in_ready=0; register the phase-0 sum into Y, out_valid<=1, out_phase<=0; -> PH1.
  - PH1: in_ready=1; register the phase-1 sum into Y, out_valid<=1, out_phase<=1.
    - If an accept occurs in the same cycle -> PH0. The shift and the phase-1 computation both use the pre-shift delay line.
    - Otherwise -> IDLE.
- Latency: sample accepted at edge t gives phase-0 Y valid after edge t+1 and phase-1 Y valid after edge t+2.
- Maximum input rate is one sample per 2 clocks. At full rate out_valid stays high continuously with out_phase alternating 0,1.
- In IDLE and on cycles with no new output: out_valid=0. Y holds its last value and out_phase holds its value.
- in_valid while in PH0: the sample is not accepted; the source must hold X and in_valid.
- Reset (asynchronous, any time, including mid-pair):
  - d[*]=0, state=IDLE, Y=0, out_valid=0, out_phase=0.
  - A pending phase-1 output is discarded.
  - in_ready=1 immediately after reset asserts (state=IDLE).
- The first 10 input pairs after reset use zero history. This is the normal filter start-up; no flag is provided.

Test Plan:
- Impulse at full rate: X=1, then X=0 accepted every 2 cycles -> Y stream (out_valid run) = -1,2,8,7,-9,-33,-31,27,133,229,253,187,77,-9,-37,-22,1,9,5,0,-1, then zeros; out_phase alternates 0,1 starting at 0.
- DC max: X=127 held for 12 or more accepts -> steady Y alternates 50546 (phase 0) and 50419 (phase 1).
- DC min: X=-128 held -> steady Y alternates -50944 / -50816; no wrap, sign correct on all 20 bits.
- Throttled input: in_valid pulsed once every 5 cycles with the impulse sequence -> same 21 values as the impulse test. Each pair occupies two consecutive out_valid cycles; out_valid=0 between pairs; in_ready=0 only in the PH0 cycle.
- Hold in PH0: in_valid held high continuously with a new X offered every cycle -> a sample is accepted only when in_ready=1 (every 2nd cycle); no sample is lost or duplicated relative to the accepted sequence.
- Reset mid-pair: assert reset during the PH1 cycle after an accept of 100 -> Y=0, out_valid=0, in_ready=1 immediately. After release, an impulse test reproduces the exact h[] sequence with no residue of 100.
